// File: rtl/proc_run_pkg.sv
// Shared types and constants for the processor run controller.
package proc_run_pkg;

  localparam int PC_W  = 64;
  localparam int CYC_W = 16;

  localparam int DEF_RESET_CYCLES  = 1;
  localparam int DEF_CAPTURE_DELAY = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_CAPTURE,
    ST_REPORT
  } run_state_e;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/proc_run_watchdog.sv
// Saturating RUN-cycle counter; expired flags the cycle whose count reaches a non-zero limit.
module proc_run_watchdog
  import proc_run_pkg::*;
(
  input  logic             CLK,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CYC_W-1:0] limit,
  output logic [CYC_W-1:0] count,
  output logic             expired
);

  logic [CYC_W-1:0] count_inc;

  // expired looks at the post-increment value so the final count equals the limit.
  always_comb begin
    count_inc = sat_inc(count);
    expired   = enable && (limit != '0) && (count_inc == limit);
  end

  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: holds the processor in reset, runs it to an end PC or watchdog
// expiry, samples data memory and reports pass/fail with a one-cycle done pulse.
module proc_run_ctrl
  import proc_run_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int CAPTURE_DELAY = DEF_CAPTURE_DELAY
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  startpc_in,
  input  logic [PC_W-1:0]  endpc,
  input  logic [PC_W-1:0]  expected,
  input  logic [CYC_W-1:0] timeout,
  input  logic [PC_W-1:0]  currentpc,
  input  logic [PC_W-1:0]  dmemout,
  output logic             proc_resetl,
  output logic [PC_W-1:0]  proc_startpc,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic [PC_W-1:0]  result,
  output logic [CYC_W-1:0] cycles
);

  // Both delays are treated as at least one cycle.
  localparam logic [15:0] HOLD_LAST = (RESET_CYCLES > 1)  ? 16'(RESET_CYCLES - 1)  : 16'd0;
  localparam logic [15:0] CAP_LAST  = (CAPTURE_DELAY > 1) ? 16'(CAPTURE_DELAY - 1) : 16'd0;

  run_state_e       state, state_next;
  logic [15:0]      phase_cnt;
  logic [PC_W-1:0]  startpc_q, endpc_q, expected_q, result_q;
  logic [CYC_W-1:0] timeout_q;
  logic             pass_q, timed_out_q;
  logic             accept, end_hit, wd_expired, run_timeout, capture_now;

  proc_run_watchdog u_watchdog (
    .CLK     (CLK),
    .reset   (reset),
    .clear   (accept),
    .enable  (state == ST_RUN),
    .limit   (timeout_q),
    .count   (cycles),
    .expired (wd_expired)
  );

  // End-PC takes priority over the watchdog when both fire in the same cycle.
  always_comb begin
    accept      = (state == ST_IDLE) && start;
    end_hit     = (currentpc >= endpc_q);
    run_timeout = (state == ST_RUN) && !end_hit && wd_expired;
    capture_now = (state == ST_CAPTURE) && (phase_cnt == CAP_LAST);
    state_next  = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_HOLD;
      ST_HOLD:    if (phase_cnt == HOLD_LAST) state_next = ST_RUN;
      ST_RUN: begin
        if (end_hit)         state_next = ST_CAPTURE;
        else if (wd_expired) state_next = ST_REPORT;
      end
      ST_CAPTURE: if (capture_now) state_next = ST_REPORT;
      ST_REPORT:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= ST_IDLE;
      phase_cnt   <= '0;
      startpc_q   <= '0;
      endpc_q     <= '0;
      expected_q  <= '0;
      timeout_q   <= '0;
      result_q    <= '0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state     <= state_next;
      phase_cnt <= (state_next == state) ? phase_cnt + 16'd1 : 16'd0;
      if (accept) begin
        startpc_q   <= startpc_in;
        endpc_q     <= endpc;
        expected_q  <= expected;
        timeout_q   <= timeout;
        result_q    <= '0;
        pass_q      <= 1'b0;
        timed_out_q <= 1'b0;
      end
      if (run_timeout) begin
        timed_out_q <= 1'b1;
        pass_q      <= 1'b0;
      end
      // Pass is resolved on entry to REPORT so it is valid alongside done.
      if (capture_now) begin
        result_q <= dmemout;
        pass_q   <= (dmemout == expected_q);
      end
    end
  end

  always_comb begin
    proc_resetl  = (state == ST_RUN) || (state == ST_CAPTURE);
    busy         = (state != ST_IDLE);
    done         = (state == ST_REPORT);
    proc_startpc = startpc_q;
    pass         = pass_q;
    timed_out    = timed_out_q;
    result       = result_q;
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Randomized and directed bench for proc_run_ctrl against a per-run schedule model.
module tb_proc_run_ctrl;

  localparam int R = 2;
  localparam int D = 3;

  logic        CLK = 1'b0;
  logic        reset, start;
  logic [63:0] startpc_in, endpc, expected, currentpc, dmemout;
  logic [15:0] timeout;
  logic        proc_resetl, busy, done, pass, timed_out;
  logic [63:0] proc_startpc, result;
  logic [15:0] cycles;

  int n_cmp  = 0;
  int n_fail = 0;

  proc_run_ctrl #(.RESET_CYCLES(R), .CAPTURE_DELAY(D)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start),
    .startpc_in   (startpc_in),
    .endpc        (endpc),
    .expected     (expected),
    .timeout      (timeout),
    .currentpc    (currentpc),
    .dmemout      (dmemout),
    .proc_resetl  (proc_resetl),
    .proc_startpc (proc_startpc),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timed_out    (timed_out),
    .result       (result),
    .cycles       (cycles)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag, input bit e_busy, input bit e_rl, input bit e_done,
                           input int e_cyc, input logic [63:0] e_sp, input bit e_pass,
                           input bit e_to, input logic [63:0] e_res);
    check_output({tag, ".busy"},        64'(busy),        64'(e_busy));
    check_output({tag, ".proc_resetl"}, 64'(proc_resetl), 64'(e_rl));
    check_output({tag, ".done"},        64'(done),        64'(e_done));
    check_output({tag, ".cycles"},      64'(cycles),      64'(e_cyc));
    check_output({tag, ".startpc"},     proc_startpc,     e_sp);
    check_output({tag, ".pass"},        64'(pass),        64'(e_pass));
    check_output({tag, ".timed_out"},   64'(timed_out),   64'(e_to));
    check_output({tag, ".result"},      result,           e_res);
  endtask

  // One complete run. k is the RUN cycle (1-based) on which the PC first reaches endpc.
  task automatic apply_stimulus(input string name, input logic [63:0] sp, input logic [63:0] ep,
                                input logic [63:0] ex, input logic [15:0] to, input int k,
                                input bit hang, input logic [63:0] dval, input int glitch,
                                input int abort_at);
    bit          captured, fin;
    int          n, last, cap_step, e_cyc;
    logic [63:0] res_exp;
    bit          pass_exp;
    string       tag;

    captured = !hang && !(to != 0 && int'(to) < k);
    n        = captured ? k : int'(to);
    cap_step = R + n + D;
    last     = captured ? cap_step + 1 : R + n + 1;
    res_exp  = captured ? dval : 64'd0;
    pass_exp = captured && (dval == ex);

    start = 1'b1; startpc_in = sp; endpc = ep; expected = ex; timeout = to;
    currentpc = rand64() % ep; dmemout = rand64();
    step();

    for (int s = 1; s <= last + 2; s++) begin
      tag   = $sformatf("%s.s%0d", name, s);
      fin   = (s >= last);
      e_cyc = (s <= R) ? 0 : ((s <= R + n) ? s - R - 1 : n);
      check_all(tag, s <= last, (s > R) && (s < last), s == last, e_cyc, sp,
                fin ? pass_exp : 1'b0, fin ? !captured : 1'b0, fin ? res_exp : 64'd0);

      if (s == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        step();
        check_all({name, ".abort"}, 1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b0, 1'b0, 64'd0);
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
          step();
          check_output($sformatf("%s.post_abort%0d.done", name, j), 64'(done), 64'd0);
          check_output($sformatf("%s.post_abort%0d.busy", name, j), 64'(busy), 64'd0);
        end
        return;
      end

      // Scramble the run inputs to prove the controller uses its latched copies.
      start      = (s == glitch);
      startpc_in = rand64();
      endpc      = rand64();
      expected   = rand64();
      timeout    = 16'($urandom);
      if ((s > R) && (s <= R + n) && !hang && (s - R >= k))
        currentpc = ep + 64'($urandom_range(0, 3));
      else
        currentpc = rand64() % ep;
      dmemout = (captured && s == cap_step) ? dval : rand64();
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    logic [63:0] ep, ex, dv;
    logic [15:0] to;
    bit          hang;
    int          k, gl;

    reset = 1'b1; start = 1'b0;
    startpc_in = rand64(); endpc = rand64(); expected = rand64();
    timeout = 16'hFFFF; currentpc = rand64(); dmemout = rand64();
    step();
    step();
    check_all("reset", 1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b0, 1'b0, 64'd0);
    reset = 1'b0;
    step();

    apply_stimulus("normal",   64'h0, 64'h34, 64'hF, 16'hFF, 5, 1'b0, 64'hF, -1, -1);
    apply_stimulus("mismatch", 64'h0, 64'h34, 64'hF, 16'hFF, 5, 1'b0, 64'h123456789ABCDEF0, -1, -1);
    apply_stimulus("hang",     64'h0, 64'h34, 64'hF, 16'hFF, 0, 1'b1, 64'hF, -1, -1);
    apply_stimulus("tie",      64'h40, 64'h80, 64'h5A, 16'd8, 8, 1'b0, 64'h5A, -1, -1);
    apply_stimulus("early_to", 64'h40, 64'h80, 64'h5A, 16'd4, 10, 1'b0, 64'h5A, -1, -1);
    apply_stimulus("abort",    64'h1000, 64'h2000, 64'h7, 16'd0, 20, 1'b0, 64'h7, -1, R + 3);
    apply_stimulus("glitch",   64'h200, 64'h300, 64'h9, 16'd0, 6, 1'b0, 64'h9, R + 2, -1);
    apply_stimulus("no_wdog",  64'h8, 64'hFFFF, 64'h1, 16'd0, 40, 1'b0, 64'h1, -1, -1);

    for (int i = 0; i < 20; i++) begin
      ep = {1'b0, rand64() >> 1};
      if (ep == 64'd0) ep = 64'd1;
      ex   = rand64();
      to   = 16'($urandom_range(0, 30));
      hang = (to != 16'd0) && ($urandom_range(0, 3) == 0);
      k    = $urandom_range(1, 30);
      dv   = ($urandom_range(0, 1) == 1) ? ex : rand64();
      gl   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, R + 1) : -1;
      apply_stimulus($sformatf("rand%0d", i), rand64(), ep, ex, to, k, hang, dv, gl, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
